// File: rtl/dcache_pkg.sv
// Shared widths, address field layout and FSM state type for the L1 data cache.
package dcache_pkg;

    localparam int NUM_LINES      = 8;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int ADDR_W         = 30;
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int TAG_W          = ADDR_W - OFF_W - IDX_W;
    localparam int LADDR_W        = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // Word 0 sits in the least significant bits of a line.
    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        return line[32'(off)*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty bits (cleared by reset), tags and 128-bit data.
// Tag and data contents are meaningless until the valid bit is set, so they
// carry no reset.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [OFF_W-1:0]  word_off,
    input  logic [WORD_W-1:0] word_data,
    input  logic              fill_we,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Status bits: a fill makes the line valid and clean, a store dirties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
                dirty_q[fill_idx] <= 1'b0;
            end
            if (word_we) begin
                dirty_q[word_idx] <= 1'b1;
            end
        end
    end

    // Tag and data writes: whole-line refill or single-word store merge.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end
        if (word_we) begin
            data_q[word_idx][32'(word_off)*WORD_W +: WORD_W] <= word_data;
        end
    end

    // Asynchronous read of the indexed line.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_dirty = dirty_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_line  = data_q[rd_idx];
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits complete with no stall; a miss writes back a dirty victim line, then
// refills the line and lets IDLE re-evaluate the request as a hit.
//
//   state     | meaning
//   IDLE      | serve hits; on a miss pick WRITEBACK or ALLOCATE
//   WRITEBACK | dirty victim line offered to memory until mem_ready
//   ALLOCATE  | refill of the requested line until mem_ready
module l1_dcache
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               proc_read,
    input  logic               proc_write,
    input  logic [ADDR_W-1:0]  proc_addr,
    input  logic [WORD_W-1:0]  proc_wdata,
    output logic               proc_stall,
    output logic [WORD_W-1:0]  proc_rdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready
);

    state_t state_q, state_d;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              req;
    logic              hit;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              word_we;
    logic              fill_we;

    assign off = proc_addr[OFF_W-1:0];
    assign idx = proc_addr[IDX_W+OFF_W-1:OFF_W];
    assign tag = proc_addr[ADDR_W-1:IDX_W+OFF_W];
    assign req = proc_read | proc_write;
    assign hit = rd_valid && (rd_tag == tag);

    dcache_line_array u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_idx  (idx),
        .word_off  (off),
        .word_data (proc_wdata),
        .fill_we   (fill_we),
        .fill_idx  (idx),
        .fill_tag  (tag),
        .fill_line (mem_rdata)
    );

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, processor/memory outputs and array write enables.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        word_we    = 1'b0;
        fill_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read and write is served as a write.
                        if (proc_write) begin
                            word_we = 1'b1;
                        end else begin
                            proc_rdata = get_word(rd_line, off);
                        end
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, idx};
                mem_wdata  = rd_line;
                if (mem_ready) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:OFF_W];
                if (mem_ready) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held every output is quiet, even with a request
        // pending against the now-invalid lines.
        if (rst) begin
            state_d    = IDLE;
            proc_stall = 1'b0;
            proc_rdata = '0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            word_we    = 1'b0;
            fill_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios followed by random
// loads/stores, compared against an array-based cache and memory model.
module tb_l1_dcache;

    logic         clk;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cache contents per line plus backing memory per line address.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [24:0]  m_tag   [8];
    logic [31:0]  m_data  [8][4];
    logic [127:0] mem_m   [logic [27:0]];

    l1_dcache dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_get(input logic [27:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {{4'hD, a}, {4'hC, a}, {4'hB, a}, {4'hA, a}};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_stall"}, proc_stall, 0);
        chk({tag, "_rdata"}, proc_rdata, 0);
        chk({tag, "_mem"}, {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    endtask

    // One load (wr=0) or store (wr=1) driven to completion; memory answers the
    // write-back after w_lat cycles and the refill after n_lat cycles.
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                          input int w_lat, input int n_lat);
        logic [2:0]   idx;
        logic [24:0]  tg;
        logic [1:0]   off;
        bit           hit;
        bit           dv;
        logic [127:0] vline;
        logic [127:0] rl;
        logic [27:0]  vaddr;
        int           stalls;
        int           exp_st;
        idx    = a[4:2];
        tg     = a[29:5];
        off    = a[1:0];
        hit    = m_valid[idx] && (m_tag[idx] == tg);
        dv     = m_valid[idx] && m_dirty[idx];
        vline  = {m_data[idx][3], m_data[idx][2], m_data[idx][1], m_data[idx][0]};
        vaddr  = {m_tag[idx], idx};
        rl     = mem_get(a[29:2]);
        stalls = 0;
        exp_st = hit ? 0 : (dv ? 1 + w_lat + n_lat : 1 + n_lat);

        @(negedge clk);
        mem_ready  = 1'b0;
        proc_read  = !wr;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        #1;
        if (!hit) begin
            chk("miss_c0_mem", {mem_read, mem_write}, 0);
            stalls += int'(proc_stall);
            if (dv) begin
                for (int i = 1; i <= w_lat; i++) begin
                    @(negedge clk);
                    mem_ready = 1'b0;
                    #1;
                    chk("wb_rw", {mem_read, mem_write}, 2'b01);
                    chk("wb_addr", mem_addr, vaddr);
                    chk("wb_data", mem_wdata, vline);
                    stalls += int'(proc_stall);
                    if (i == w_lat) mem_ready = 1'b1;
                end
            end
            mem_rdata = rl;
            for (int i = 1; i <= n_lat; i++) begin
                @(negedge clk);
                mem_ready = 1'b0;
                #1;
                chk("fill_rw", {mem_read, mem_write}, 2'b10);
                chk("fill_addr", mem_addr, a[29:2]);
                stalls += int'(proc_stall);
                if (i == n_lat) mem_ready = 1'b1;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (dv) mem_m[vaddr] = vline;
            for (int k = 0; k < 4; k++) m_data[idx][k] = rl[32*k +: 32];
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        chk("done_stall", proc_stall, 0);
        chk("done_mem", {mem_read, mem_write}, 0);
        if (!wr) chk("rdata", proc_rdata, m_data[idx][off]);
        chk("stall_cycles", stalls, exp_st);
        if (wr) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1'b1;
        end
        @(negedge clk);
        proc_read  = 1'b0;
        proc_write = 1'b0;
        #1;
        chk_idle_outputs("idle");
    endtask

    initial begin
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        model_reset();
        #2;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed walk through the basic hit/miss/write-back sequence.
        mem_m[28'h0000004] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        access(0, 30'h0000010, 32'h0, 1, 3);
        chk("first_read", proc_rdata, 32'h0);
        access(0, 30'h0000011, 32'h0, 1, 1);
        access(1, 30'h0000012, 32'h12345678, 1, 1);
        access(0, 30'h0000012, 32'h0, 1, 1);
        access(0, 30'h0000032, 32'h0, 2, 2);
        chk("wb_merged", mem_get(28'h0000004), 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA);

        // Store miss to a clean line, then a conflicting miss evicts the merged word.
        access(1, 30'h0000041, 32'hCAFEF00D, 1, 2);
        access(0, 30'h0000060, 32'h0, 3, 1);
        access(0, 30'h0000041, 32'h0, 1, 1);

        // Reset while a refill is pending.
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h0000077;
        #1;
        @(negedge clk);
        #1;
        chk("pre_rst_alloc", {mem_read, mem_write}, 2'b10);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid_alloc");
        @(negedge clk);
        rst       = 1'b0;
        proc_read = 1'b0;
        model_reset();
        access(0, 30'h0000077, 32'h0, 1, 2);
        access(0, 30'h0000041, 32'h0, 1, 1);

        // Random loads and stores over a few tags per index to mix hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            logic [29:0] a;
            a = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            if ($urandom_range(0, 7) == 0) begin
                // Stray completion pulse while idle must be ignored.
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                #1;
                chk_idle_outputs("stray_ready");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
